shift_pass_sequencer: RTL and testbench



---
 rtl/shift_pass_sequencer.sv | 144 ++++++++++++++
 tb/tb_shift_pass_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pass_sequencer.sv
// Sequences shift commands of up to 2^AMT_W-1 through an external 0..7 barrel shifter, one pass per clock.
// Optional SHIFT_LOSS_FLAG_EN adds res_loss: set when any 1 bit of the operand is shifted out.
module shift_pass_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic             cmd_dir,
  output logic [7:0]       bs_data_in,
  output logic [2:0]       bs_shift_amount,
  output logic             bs_direction,
  input  logic [7:0]       bs_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy
`ifdef SHIFT_LOSS_FLAG_EN
  ,
  output logic             res_loss
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] SEVEN = AMT_W'(7);

  state_t           state_q;
  logic [7:0]       work_q;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] rem_d;
  logic             dir_q;
  logic [2:0]       step_q;
  logic [2:0]       step_d;
  logic [2:0]       first_step;
  logic             cmd_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  function automatic logic [2:0] clamp7(input logic [AMT_W-1:0] a);
    return (a > SEVEN) ? 3'd7 : a[2:0];
  endfunction

  // step_q always holds min(rem_q, 7) while in PASS, and 0 elsewhere
  assign rem_d      = rem_q - AMT_W'(step_q);
  assign step_d     = clamp7(rem_d);
  assign first_step = clamp7(cmd_amount);

  assign cmd_ready       = cmd_ready_q;
  assign res_valid       = res_valid_q;
  assign busy            = busy_q;
  assign res_data        = work_q;
  assign bs_data_in      = work_q;
  assign bs_shift_amount = step_q;
  assign bs_direction    = dir_q;

`ifdef SHIFT_LOSS_FLAG_EN
  logic       loss_q;
  logic       loss_d;
  logic [7:0] lmask;
  logic [7:0] rmask;

  // Masks select the bits that fall off the end for amounts 0..7
  assign lmask  = ~(8'hFF >> cmd_amount[2:0]);
  assign rmask  = ~(8'hFF << cmd_amount[2:0]);
  assign loss_d = (cmd_amount > SEVEN) ? (cmd_data != 8'h00)
                : ((cmd_data & (cmd_dir ? rmask : lmask)) != 8'h00);
  assign res_loss = loss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= 1'b0;
    end else if (state_q == IDLE && cmd_valid) begin
      loss_q <= loss_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= 8'h00;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 3'd0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            work_q      <= cmd_data;
            rem_q       <= cmd_amount;
            dir_q       <= cmd_dir;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_amount != '0) begin
              state_q <= PASS;
              step_q  <= first_step;
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        PASS: begin
          work_q <= bs_data_out;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q     <= DONE;
            step_q      <= 3'd0;
            res_valid_q <= 1'b1;
          end else begin
            step_q <= step_d;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          step_q      <= 3'd0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer; a behavioural 8-bit barrel shifter closes the loop.
// Edge numbering in the notes below: edge 1 is the edge that accepts the command.
module tb_shift_pass_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [3:0] cmd_amount;
  logic       cmd_dir;
  logic [7:0] bs_data_in;
  logic [2:0] bs_shift_amount;
  logic       bs_direction;
  logic [7:0] bs_data_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
`ifdef SHIFT_LOSS_FLAG_EN
  logic       res_loss;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign bs_data_out = bs_direction ? (bs_data_in >> bs_shift_amount)
                                    : (bs_data_in << bs_shift_amount);

  shift_pass_sequencer #(.AMT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .cmd_amount(cmd_amount),
    .cmd_dir(cmd_dir),
    .bs_data_in(bs_data_in),
    .bs_shift_amount(bs_shift_amount),
    .bs_direction(bs_direction),
    .bs_data_out(bs_data_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy)
`ifdef SHIFT_LOSS_FLAG_EN
    ,
    .res_loss(res_loss)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_loss(input string tag, input logic exp);
`ifdef SHIFT_LOSS_FLAG_EN
    chk(tag, {7'd0, res_loss}, {7'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] a, input logic dir);
    cmd_data   = d;
    cmd_amount = a;
    cmd_dir    = dir;
    cmd_valid  = 1'b1;
  endtask

  task automatic handoff(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_rv_low"}, {7'd0, res_valid}, 8'd0);
    chk({tag, "_crdy"},   {7'd0, cmd_ready}, 8'd1);
    chk({tag, "_busy"},   {7'd0, busy},      8'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_data = 8'h00; cmd_amount = 4'd0; cmd_dir = 1'b0;
    #12;
    chk("rst_crdy", {7'd0, cmd_ready}, 8'd1);
    chk("rst_rv",   {7'd0, res_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy},      8'd0);
    chk("rst_rdat", res_data,          8'h00);
    chk("rst_bsin", bs_data_in,        8'h00);
    chk("rst_bsam", {5'd0, bs_shift_amount}, 8'd0);
    chk("rst_bsdir", {7'd0, bs_direction}, 8'd0);
    chk_loss("rst_loss", 1'b0);
    tick();
    rst = 1'b0;

    // B5 << 3 in a single pass
    send(8'hB5, 4'd3, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("t1_bsam", {5'd0, bs_shift_amount}, 8'd3);
    chk("t1_bsin", bs_data_in, 8'hB5);
    chk("t1_rv_early", {7'd0, res_valid}, 8'd0);
    chk("t1_crdy", {7'd0, cmd_ready}, 8'd0);
    chk("t1_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("t1_rv", {7'd0, res_valid}, 8'd1);
    chk("t1_rdat", res_data, 8'hA8);
    chk("t1_bsam0", {5'd0, bs_shift_amount}, 8'd0);
    chk_loss("t1_loss", 1'b1);
    handoff("t1");

    // F0 >> 10 as passes of 7 then 3
    send(8'hF0, 4'd10, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_p1_am", {5'd0, bs_shift_amount}, 8'd7);
    chk("t2_p1_dir", {7'd0, bs_direction}, 8'd1);
    tick();
    chk("t2_p2_am", {5'd0, bs_shift_amount}, 8'd3);
    chk("t2_p2_in", bs_data_in, 8'h01);
    chk("t2_rv_early", {7'd0, res_valid}, 8'd0);
    tick();
    chk("t2_rv", {7'd0, res_valid}, 8'd1);
    chk("t2_rdat", res_data, 8'h00);
    chk_loss("t2_loss", 1'b1);
    handoff("t2");

    // amount 0 goes straight to DONE
    send(8'h81, 4'd0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("t3_rv", {7'd0, res_valid}, 8'd1);
    chk("t3_rdat", res_data, 8'h81);
    chk("t3_bsam", {5'd0, bs_shift_amount}, 8'd0);
    chk_loss("t3_loss", 1'b0);
    handoff("t3");

    // 01 << 15 as 7, 7, 1 with result held under backpressure
    send(8'h01, 4'd15, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("t4_p1_am", {5'd0, bs_shift_amount}, 8'd7);
    tick();
    chk("t4_p2_am", {5'd0, bs_shift_amount}, 8'd7);
    chk("t4_p2_in", bs_data_in, 8'h80);
    tick();
    chk("t4_p3_am", {5'd0, bs_shift_amount}, 8'd1);
    chk("t4_p3_in", bs_data_in, 8'h00);
    chk("t4_crdy_p", {7'd0, cmd_ready}, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rv", {7'd0, res_valid}, 8'd1);
      chk("t4_hold_dat", res_data, 8'h00);
      chk("t4_hold_crdy", {7'd0, cmd_ready}, 8'd0);
      tick();
    end
    chk_loss("t4_loss", 1'b1);
    handoff("t4");

    // back-to-back with cmd_valid held high across the hand-off
    send(8'h0F, 4'd2, 1'b1);
    tick();
    chk("t5a_am", {5'd0, bs_shift_amount}, 8'd2);
    tick();
    chk("t5a_rv", {7'd0, res_valid}, 8'd1);
    chk("t5a_rdat", res_data, 8'h03);
    chk_loss("t5a_loss", 1'b1);
    send(8'h0F, 4'd2, 1'b0);
    tick();
    chk("t5_ignored_dat", res_data, 8'h03);
    chk("t5_ignored_crdy", {7'd0, cmd_ready}, 8'd0);
    handoff("t5a");
    tick();
    chk("t5b_busy", {7'd0, busy}, 8'd1);
    chk("t5b_am", {5'd0, bs_shift_amount}, 8'd2);
    chk("t5b_dir", {7'd0, bs_direction}, 8'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t5b_rv", {7'd0, res_valid}, 8'd1);
    chk("t5b_rdat", res_data, 8'h3C);
    chk_loss("t5b_loss", 1'b0);
    handoff("t5b");

    // reset during the second pass of an amount-14 command
    send(8'hFF, 4'd14, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_p2_in", bs_data_in, 8'h80);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_rv", {7'd0, res_valid}, 8'd0);
    chk("t6_rst_busy", {7'd0, busy}, 8'd0);
    chk("t6_rst_crdy", {7'd0, cmd_ready}, 8'd1);
    chk("t6_rst_bsam", {5'd0, bs_shift_amount}, 8'd0);
    chk("t6_rst_bsin", bs_data_in, 8'h00);
    chk("t6_rst_rdat", res_data, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_rv", {7'd0, res_valid}, 8'd0);
    send(8'h3C, 4'd1, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_rv", {7'd0, res_valid}, 8'd1);
    chk("t6_rdat", res_data, 8'h1E);
    chk_loss("t6_loss", 1'b0);
    handoff("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
